// File: rtl/reg_file_master_pkg.sv
// Shared definitions for the UART-to-register-file command initiator:
// default geometry, frame opcodes, read timeout and the FSM state encoding.
package reg_file_master_pkg;

    localparam int         DEF_REG_WIDTH  = 8;
    localparam int         DEF_ADDR_WIDTH = 4;
    localparam logic [7:0] DEF_WR_CMD     = 8'hAA;
    localparam logic [7:0] DEF_RD_CMD     = 8'hBB;
    localparam int         DEF_RD_TIMEOUT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_ISSUE,
        ST_RD_ADDR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_TX_SEND
    } state_e;

    // Width of a down-counter that must hold the value (timeout - 1).
    function automatic int tmo_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/reg_file_master.sv
// Parses {AA,addr,data} write and {BB,addr} read frames from the UART byte
// stream, drives the register-file strobes and returns read bytes to UART TX.
module reg_file_master
    import reg_file_master_pkg::*;
#(
    parameter int                   REG_WIDTH  = DEF_REG_WIDTH,
    parameter int                   ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [REG_WIDTH-1:0] WR_CMD     = REG_WIDTH'(DEF_WR_CMD),
    parameter logic [REG_WIDTH-1:0] RD_CMD     = REG_WIDTH'(DEF_RD_CMD),
    parameter int                   RD_TIMEOUT = DEF_RD_TIMEOUT
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [REG_WIDTH-1:0]  i_RX_Data,
    input  logic                  i_RX_Valid,
    output logic                  o_WrEn,
    output logic                  o_RdEn,
    output logic [ADDR_WIDTH-1:0] o_Address,
    output logic [REG_WIDTH-1:0]  o_WrData,
    input  logic [REG_WIDTH-1:0]  i_RdData,
    input  logic                  i_RdData_Valid,
    output logic [REG_WIDTH-1:0]  o_TX_Data,
    output logic                  o_TX_Valid,
    input  logic                  i_TX_Busy,
    output logic                  o_Err
);

    localparam int TMO_W = tmo_width(RD_TIMEOUT);

    state_e                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  err_q, err_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
    logic [REG_WIDTH-1:0]  txd_q, txd_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  addr_ovf;

    // An address byte is only legal when every bit above the address field is clear.
    assign addr_ovf = |(i_RX_Data >> ADDR_WIDTH);

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        err_d      = 1'b0;
        tx_valid_d = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        txd_d      = txd_q;
        tmo_d      = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (i_RX_Valid) begin
                    if (i_RX_Data == WR_CMD) begin
                        state_d = ST_WR_ADDR;
                    end else if (i_RX_Data == RD_CMD) begin
                        state_d = ST_RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_WR_ADDR, ST_RD_ADDR: begin
                if (i_RX_Valid) begin
                    addr_d = i_RX_Data[ADDR_WIDTH-1:0];
                    if (addr_ovf) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (state_q == ST_WR_ADDR) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_RD_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end
            end

            ST_WR_DATA: begin
                if (i_RX_Valid) begin
                    wdata_d = i_RX_Data;
                    state_d = ST_WR_ISSUE;
                    wr_en_d = 1'b1;
                end
            end

            ST_WR_ISSUE: begin
                err_d   = i_RX_Valid;
                state_d = ST_IDLE;
            end

            ST_RD_ISSUE: begin
                err_d   = i_RX_Valid;
                tmo_d   = TMO_W'(RD_TIMEOUT - 1);
                state_d = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                err_d = i_RX_Valid;
                if (i_RdData_Valid) begin
                    txd_d = i_RdData;
                    // With TX already free the byte goes out next cycle; TX_SEND only
                    // holds it while the transmitter is busy.
                    if (!i_TX_Busy) begin
                        tx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_TX_SEND;
                    end
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end

            ST_TX_SEND: begin
                err_d = i_RX_Valid;
                if (!i_TX_Busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            txd_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            txd_q      <= txd_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_WrEn     = wr_en_q;
    assign o_RdEn     = rd_en_q;
    assign o_Err      = err_q;
    assign o_TX_Valid = tx_valid_q;
    assign o_Address  = addr_q;
    assign o_WrData   = wdata_q;
    assign o_TX_Data  = txd_q;

endmodule

// File: tb/tb_reg_file_master.sv
// Randomized frame-level bench for reg_file_master: a transaction model predicts
// per-cycle strobes, errors and TX bytes, and one negedge process compares them.
`timescale 1ns/1ps
module tb_reg_file_master;

    localparam int MAXC = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en, rd_en, err, tx_valid;
    logic [3:0] addr;
    logic [7:0] wr_data, rd_data, tx_data;
    logic       rd_valid;
    logic       tx_busy;

    reg_file_master dut (
        .i_CLK(clk), .i_RST(rst),
        .i_RX_Data(rx_data), .i_RX_Valid(rx_valid),
        .o_WrEn(wr_en), .o_RdEn(rd_en), .o_Address(addr), .o_WrData(wr_data),
        .i_RdData(rd_data), .i_RdData_Valid(rd_valid),
        .o_TX_Data(tx_data), .o_TX_Valid(tx_valid), .i_TX_Busy(tx_busy),
        .o_Err(err)
    );

    always #5 clk = ~clk;

    // Expected behaviour per cycle, filled in by the transaction model.
    bit         exp_wr  [MAXC];
    logic [3:0] exp_wa  [MAXC];
    logic [7:0] exp_wd  [MAXC];
    bit         exp_rd  [MAXC];
    logic [3:0] exp_ra  [MAXC];
    bit         exp_err [MAXC];
    bit         exp_tx  [MAXC];
    bit         exp_tdc [MAXC];
    logic [7:0] exp_td  [MAXC];
    bit         lit_tx_en  [MAXC];
    logic [7:0] lit_tx_val [MAXC];
    bit         busy_sched [MAXC];
    logic [7:0] shadow [16];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;
    bit rf_drop = 1'b0;

    // Register-file model: writes land next cycle, read data one cycle after RdEn.
    logic [7:0] mem [16];
    bit mem_ok = 1'b0;
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h1D + 8'(i);
            mem_ok <= 1'b1;
        end else if (wr_en) begin
            mem[addr] <= wr_data;
        end
        rd_valid <= rd_en && !rf_drop;
        rd_data  <= rd_en ? mem[addr] : 8'($urandom);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endfunction

    always @(negedge clk) begin
        if (!done && cyc > 0 && cyc < MAXC) begin
            chk("wr_en", 32'(wr_en), 32'(exp_wr[cyc]));
            chk("rd_en", 32'(rd_en), 32'(exp_rd[cyc]));
            chk("err", 32'(err), 32'(exp_err[cyc]));
            chk("tx_valid", 32'(tx_valid), 32'(exp_tx[cyc]));
            if (exp_wr[cyc]) begin
                chk("wr_addr", 32'(addr), 32'(exp_wa[cyc]));
                chk("wr_data", 32'(wr_data), 32'(exp_wd[cyc]));
            end
            if (exp_rd[cyc]) chk("rd_addr", 32'(addr), 32'(exp_ra[cyc]));
            if (exp_tdc[cyc]) chk("tx_data", 32'(tx_data), 32'(exp_td[cyc]));
            if (lit_tx_en[cyc]) chk("tx_literal", 32'({tx_valid, tx_data}), 32'({1'b1, lit_tx_val[cyc]}));
            if (rst) chk("reset_data", 32'({addr, wr_data, tx_data}), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        tx_busy = (cyc < MAXC) ? busy_sched[cyc] : 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int gmax, input bit stray);
        int c;
        send_byte(8'hAA);
        gap($urandom_range(0, gmax));
        send_byte({4'h0, a});
        gap($urandom_range(0, gmax));
        c = cyc;
        exp_wr[c+1] = 1'b1;
        exp_wa[c+1] = a;
        exp_wd[c+1] = d;
        shadow[a]   = d;
        send_byte(d);
        if (stray) begin
            exp_err[c+2] = 1'b1;
            send_byte(8'($urandom));
        end else begin
            tick();
        end
    endtask

    task automatic do_read(input logic [3:0] a, input int busy_len, input bit stray, input bit drop,
                           input int gmax, input bit lit, input logic [7:0] lit_val);
        int c, b, fin, s;
        send_byte(8'hBB);
        gap($urandom_range(0, gmax));
        c = cyc;
        exp_rd[c+1] = 1'b1;
        exp_ra[c+1] = a;
        if (drop) begin
            rf_drop = 1'b1;
            fin = c + 6;
            exp_err[fin] = 1'b1;
        end else begin
            for (int k = 0; k < busy_len; k++) busy_sched[c+2+k] = 1'b1;
            b   = c + 2 + busy_len;
            fin = b + 1;
            exp_tx[fin] = 1'b1;
            for (int k = c + 3; k <= fin; k++) begin
                exp_tdc[k] = 1'b1;
                exp_td[k]  = shadow[a];
            end
            if (lit) begin
                lit_tx_en[fin]  = 1'b1;
                lit_tx_val[fin] = lit_val;
            end
        end
        s = -1;
        if (stray) begin
            s = int'($urandom_range(c + 1, fin - 1));
            exp_err[s+1] = 1'b1;
        end
        send_byte({4'h0, a});
        while (cyc < fin) begin
            if (cyc == s) send_byte(8'($urandom));
            else tick();
        end
        rf_drop = 1'b0;
    endtask

    task automatic bad_opcode(input logic [7:0] v);
        exp_err[cyc+1] = 1'b1;
        send_byte(v);
    endtask

    task automatic bad_addr(input logic [7:0] op, input logic [7:0] abyte, input int gmax);
        send_byte(op);
        gap($urandom_range(0, gmax));
        exp_err[cyc+1] = 1'b1;
        send_byte(abyte);
    endtask

    task automatic reset_mid(input logic [7:0] op, input int g);
        send_byte(op);
        gap(g);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        int kind;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h1D + 8'(i);
        tick();
        tick();
        rst = 1'b0;

        // Directed frames, with literal TX bytes pinning the model.
        do_read(4'h3, 0, 1'b0, 1'b0, 0, 1'b1, 8'h20);
        do_write(4'h5, 8'h3C, 0, 1'b0);
        do_read(4'h5, 0, 1'b0, 1'b0, 0, 1'b1, 8'h3C);
        bad_opcode(8'h7E);
        do_write(4'h1, 8'hFF, 0, 1'b0);
        bad_addr(8'hAA, 8'h1F, 0);
        do_read(4'h1, 10, 1'b0, 1'b0, 0, 1'b1, 8'hFF);
        do_read(4'h7, 0, 1'b0, 1'b1, 0, 1'b0, 8'h00);
        reset_mid(8'hAA, 0);
        do_write(4'h2, 8'h5A, 0, 1'b0);
        do_read(4'h2, 0, 1'b0, 1'b0, 1, 1'b1, 8'h5A);
        do_write(4'h9, 8'hC3, 1, 1'b1);
        do_read(4'h9, 3, 1'b1, 1'b0, 1, 1'b1, 8'hC3);

        for (int i = 0; i < 300 && cyc < MAXC - 100; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 3) begin
                do_write(4'($urandom), 8'($urandom), 2, ($urandom_range(0, 3) == 0));
            end else if (kind <= 6) begin
                do_read(4'($urandom), int'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0),
                        ($urandom_range(0, 7) == 0), 2, 1'b0, 8'h00);
            end else if (kind == 7) begin
                v = 8'($urandom);
                while (v == 8'hAA || v == 8'hBB) v = 8'($urandom);
                bad_opcode(v);
            end else if (kind == 8) begin
                v = {4'($urandom_range(1, 15)), 4'($urandom)};
                bad_addr(($urandom_range(0, 1) == 0) ? 8'hAA : 8'hBB, v, 2);
            end else begin
                reset_mid(($urandom_range(0, 1) == 0) ? 8'hAA : 8'hBB, int'($urandom_range(0, 2)));
            end
            gap(int'($urandom_range(0, 2)));
        end

        gap(3);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
